// File: rtl/barrel_coord_sched.sv
// Credit-limited raster sequencer emitting centred Q3 {y,x} coordinates to the barrel CORDIC stage, one per cycle.
// tvalid/tdata held until tready; issue pauses at MAX_INFLIGHT; optional frame counter under BARREL_FRAME_COUNT_EN.
module barrel_coord_sched #(
  parameter int H_HALF       = 540,
  parameter int V_HALF       = 480,
  parameter int MAX_INFLIGHT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  output logic [31:0] tIn_tdata,
  output logic        tIn_tvalid,
  input  logic        tIn_tready,
  input  logic        ret_valid,
  output logic        busy,
  output logic        frame_done,
  output logic        aborted,
  output logic [4:0]  inflight,
  output logic        err,
  output logic [15:0] frame_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic signed [12:0] X_FIRST  = 13'(-H_HALF);
  localparam logic signed [12:0] X_LAST   = 13'(H_HALF - 1);
  localparam logic signed [12:0] Y_FIRST  = 13'(V_HALF);
  localparam logic signed [12:0] Y_LAST   = 13'(1 - V_HALF);
  localparam logic [4:0]         MAX_CRED = 5'(MAX_INFLIGHT);

  function automatic logic [31:0] pack(input logic signed [12:0] px, input logic signed [12:0] py);
    return {py, 3'b000, px, 3'b000};
  endfunction

  state_t             state;
  logic signed [12:0] x, y;
  logic               abort_pend;
  logic               was_aborted;

  logic               hs, ret_ok, x_wrap, last;
  logic               fin_complete, fin_abort;
  logic [4:0]         inflight_nxt;
  logic signed [12:0] x_nxt, y_nxt;

  always_comb begin
    hs           = tIn_tvalid && tIn_tready;
    ret_ok       = ret_valid && (inflight != 5'd0);
    inflight_nxt = inflight + {4'd0, hs} - {4'd0, ret_ok};
    x_wrap       = (x == X_LAST);
    last         = x_wrap && (y == Y_LAST);
    x_nxt        = x_wrap ? X_FIRST : x + 13'sd1;
    y_nxt        = x_wrap ? y - 13'sd1 : y;
    fin_complete = (state == RUN) && hs && last;
    // An abort only takes effect once no coordinate is left waiting on tready.
    fin_abort    = (state == RUN) && !fin_complete && (abort || abort_pend) && (hs || !tIn_tvalid);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      x           <= X_FIRST;
      y           <= Y_FIRST;
      tIn_tdata   <= '0;
      tIn_tvalid  <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      aborted     <= 1'b0;
      inflight    <= '0;
      abort_pend  <= 1'b0;
      was_aborted <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      aborted    <= 1'b0;
      inflight   <= inflight_nxt;
      if (hs) begin
        x         <= x_nxt;
        y         <= y_nxt;
        tIn_tdata <= pack(x_nxt, y_nxt);
      end
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            busy       <= 1'b1;
            x          <= X_FIRST;
            y          <= Y_FIRST;
            tIn_tdata  <= pack(X_FIRST, Y_FIRST);
            tIn_tvalid <= 1'b1;
            abort_pend <= 1'b0;
          end
        end
        RUN: begin
          if (fin_complete || fin_abort) begin
            tIn_tvalid  <= 1'b0;
            abort_pend  <= 1'b0;
            was_aborted <= fin_abort;
            if (inflight_nxt == 5'd0) begin
              state      <= IDLE;
              busy       <= 1'b0;
              frame_done <= fin_complete;
              aborted    <= fin_abort;
            end else begin
              state <= DRAIN;
            end
          end else if (abort && tIn_tvalid) begin
            abort_pend <= 1'b1;
          end else if (hs || !tIn_tvalid) begin
            // Counting the handshake of this cycle keeps inflight at or below MAX_INFLIGHT.
            tIn_tvalid <= (inflight_nxt < MAX_CRED);
          end
        end
        DRAIN: begin
          if (inflight_nxt == 5'd0) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= !was_aborted;
            aborted    <= was_aborted;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else if (state == IDLE && start) begin
      err <= 1'b0;
    end else if (ret_valid && inflight == 5'd0) begin
      err <= 1'b1;
    end
  end

`ifdef BARREL_FRAME_COUNT_EN
  logic count_en;
  assign count_en = (fin_complete || (state == DRAIN && !was_aborted)) && (inflight_nxt == 5'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= '0;
    end else if (count_en) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_barrel_coord_sched.sv
// Bench for barrel_coord_sched with a 4x4 frame and four credits: vector table, raster scoreboard, abort/err/reset sequences.
module tb_barrel_coord_sched;
  localparam int H = 2;
  localparam int V = 2;
  localparam int MAXI = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        tready = 1'b0;
  logic        ret_valid = 1'b0;
  logic [31:0] tdata;
  logic        tvalid, busy, frame_done, aborted, err;
  logic [4:0]  inflight;
  logic [15:0] frame_count;

  int ntests = 0;
  int nfail = 0;
  int exp_fc = 0;

  typedef struct {
    logic [3:0] stim;  // {start, abort, tready, ret_valid}
    logic [3:0] expf;  // {busy, tvalid, frame_done, aborted}
    int         inf;
    int         k;     // raster index expected on tdata
  } vec_t;

  always #5 clk = ~clk;

  barrel_coord_sched #(.H_HALF(H), .V_HALF(V), .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .tIn_tdata(tdata), .tIn_tvalid(tvalid), .tIn_tready(tready), .ret_valid(ret_valid),
    .busy(busy), .frame_done(frame_done), .aborted(aborted), .inflight(inflight),
    .err(err), .frame_count(frame_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Coordinate k of the raster: x sweeps left to right, rows descend from V.
  function automatic logic [31:0] pk(input int k);
    logic [12:0] xs, ys;
    xs = 13'(-H + k % (2 * H));
    ys = 13'(V - k / (2 * H));
    return {ys, 3'b000, xs, 3'b000};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tvalid"}, tvalid, 0);
    chk({tag, "_tdata"}, tdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_aborted"}, aborted, 0);
    chk({tag, "_inflight"}, inflight, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_frame_count"}, frame_count, 0);
  endtask

  // Runs one frame with retires echoed three cycles after each handshake.
  task automatic run_frame(input int ready_pct, input int abort_k, input int exp_hs, input bit exp_done);
    int          k = 0;
    int          ndone = 0;
    int          nab = 0;
    int          model_if = 0;
    logic [2:0]  d = '0;
    logic        prev_stall = 1'b0;
    logic        prev_ret = 1'b0;
    logic        hs_now;
    logic        finished = 1'b0;
    logic [31:0] prev_dat = '0;
    logic [31:0] first_dat = '0;
    logic [31:0] last_dat = '0;
    logic [31:0] exp_first = {13'sd2, 3'b000, -13'sd2, 3'b000};
    logic [31:0] exp_last = {-13'sd1, 3'b000, 13'sd1, 3'b000};

    start = 1'b1; tready = 1'b1; ret_valid = 1'b0; abort = 1'b0;
    step();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_err_clear", err, 0);
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      if (frame_done || aborted) begin
        finished = 1'b1;
        chk("end_busy_low", busy, 0);
        chk("end_after_retire", prev_ret, 1);
        if (frame_done) ndone++;
        if (aborted) nab++;
      end
      chk("inflight_model", inflight, model_if);
      if (prev_stall) begin
        chk("stall_tvalid", tvalid, 1);
        chk("stall_tdata", tdata, prev_dat);
      end
      if (!finished) begin
        tready = (int'($urandom_range(99, 0)) < ready_pct);
        abort = (abort_k >= 0) && (k == abort_k) && tvalid && tready;
        hs_now = tvalid && tready;
        if (hs_now) begin
          chk("raster", tdata, pk(k));
          if (k == 0) first_dat = tdata;
          last_dat = tdata;
          k++;
        end
        ret_valid = d[2];
        d = {d[1:0], hs_now};
        model_if = model_if + int'(hs_now) - int'(ret_valid);
        prev_stall = tvalid && !tready;
        prev_dat = tdata;
        prev_ret = ret_valid;
        step();
        abort = 1'b0;
      end
    end
    ret_valid = 1'b0; tready = 1'b0;
    chk("frame_finish", finished, 1);
    chk("hs_count", k, exp_hs);
    chk("done_count", ndone, exp_done);
    chk("abort_count", nab, !exp_done);
    chk("first_tdata", first_dat, exp_first);
    if (exp_done) begin
      chk("last_tdata", last_dat, exp_last);
`ifdef BARREL_FRAME_COUNT_EN
      exp_fc++;
`endif
    end
    chk("frame_count", frame_count, exp_fc);
    step();
    chk("no_extra_done", frame_done, 0);
    chk("no_extra_abort", aborted, 0);
    chk("err_clean", err, 0);
    chk("idle_tvalid", tvalid, 0);
  endtask

  initial begin
    vec_t tbl[15];
    tbl[0]  = '{4'b1010, 4'b1100, 0, 0};
    tbl[1]  = '{4'b0010, 4'b1100, 1, 1};
    tbl[2]  = '{4'b0010, 4'b1100, 2, 2};
    tbl[3]  = '{4'b0010, 4'b1100, 3, 3};
    tbl[4]  = '{4'b0010, 4'b1000, 4, 4};
    tbl[5]  = '{4'b0010, 4'b1000, 4, 4};
    tbl[6]  = '{4'b0011, 4'b1100, 3, 4};
    tbl[7]  = '{4'b0000, 4'b1100, 3, 4};
    tbl[8]  = '{4'b0010, 4'b1000, 4, 5};
    tbl[9]  = '{4'b0110, 4'b1000, 4, 5};
    tbl[10] = '{4'b0011, 4'b1000, 3, 5};
    tbl[11] = '{4'b0011, 4'b1000, 2, 5};
    tbl[12] = '{4'b0011, 4'b1000, 1, 5};
    tbl[13] = '{4'b0011, 4'b0001, 0, 5};
    tbl[14] = '{4'b0010, 4'b0000, 0, 5};

    #12;
    chk_reset_vals("rst");
    reset_n = 1'b1;
    step();
    chk_reset_vals("post_rst");

    // Credit exhaustion, single-retire refill, stall hold, abort with tvalid low, drain.
    for (int i = 0; i < 15; i++) begin
      {start, abort, tready, ret_valid} = tbl[i].stim;
      step();
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].expf[3]);
      chk($sformatf("vec%0d_tvalid", i), tvalid, tbl[i].expf[2]);
      chk($sformatf("vec%0d_frame_done", i), frame_done, tbl[i].expf[1]);
      chk($sformatf("vec%0d_aborted", i), aborted, tbl[i].expf[0]);
      chk($sformatf("vec%0d_inflight", i), inflight, tbl[i].inf);
      chk($sformatf("vec%0d_tdata", i), tdata, pk(tbl[i].k));
    end
    {start, abort, tready, ret_valid} = 4'b0000;
    step();

    run_frame(100, -1, 16, 1'b1);
    run_frame(60, -1, 16, 1'b1);
    run_frame(30, -1, 16, 1'b1);
    run_frame(100, 4, 5, 1'b0);

    ret_valid = 1'b1;
    step();
    ret_valid = 1'b0;
    chk("idle_ret_err", err, 1);
    chk("idle_ret_inflight", inflight, 0);
    step();
    chk("err_sticky", err, 1);
    run_frame(100, -1, 16, 1'b1);

    start = 1'b1; tready = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("mid_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    exp_fc = 0;
    step();
    chk("midrst_no_done", frame_done, 0);
    reset_n = 1'b1;
    tready = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_busy", busy, 1);
    chk("restart_tvalid", tvalid, 1);
    chk("restart_tdata", tdata, pk(0));
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
